axil_timer: RTL and testbench
=============================

// Module: axil_timer
// PURPOSE
//  AXI-Lite slave timer on a spare interconnect master port, beside the memory and graphics slaves.
//  Drives one level interrupt into a picorv32 irq bit (e.g. CPU_irq[3]); the CPU ISR clears it over AXI-Lite.
//  Provides a prescaled up-counter with compare match, auto-reload/one-shot modes and a W1C pending flag.
// PARAMETERS
//  ADDR_WIDTH   32  AXI-Lite address width; only addr[7:2] decoded, upper bits ignored
//  DATA_WIDTH   32  data width; only 32 supported
//  STRB_WIDTH    4  DATA_WIDTH/8
// PORTS
//  aclk             in   1   clock, all logic on rising edge
//  aresetn          in   1   asynchronous active-low reset
//  s_axil_awaddr    in   ADDR_WIDTH  write address (byte address)
//  s_axil_awprot    in   3   ignored
//  s_axil_awvalid   in   1   / s_axil_awready out 1
//  s_axil_wdata     in   32  / s_axil_wstrb in 4 / s_axil_wvalid in 1 / s_axil_wready out 1
//  s_axil_bresp     out  2   / s_axil_bvalid out 1 / s_axil_bready in 1
//  s_axil_araddr    in   ADDR_WIDTH  / s_axil_arprot in 3 (ignored) / s_axil_arvalid in 1 / s_axil_arready out 1
//  s_axil_rdata     out  32  / s_axil_rresp out 2 / s_axil_rvalid out 1 / s_axil_rready in 1
//  irq              out  1   = STATUS.pending & CTRL.irq_en, registered-source level
// BEHAVIOUR
//  Reset: all registers 0; awready/wready/arready/bvalid/rvalid=0, bresp/rresp=0, rdata=0, irq=0.
//  Map: 0x00 CTRL[2:0]={irq_en,auto_reload,enable}  0x04 STATUS[0]=pending (W1C)
//       0x08 COUNT[31:0] RW  0x0C COMPARE[31:0] RW  0x10 PRESCALE[15:0] RW (tick every PRESCALE+1 clks)
//  Unused register bits read 0, writes ignored. wstrb applied per byte on all RW regs.
//  Write: awready=wready=1 for one cycle when awvalid&wvalid&!bvalid; no separate AW/W acceptance.
//   Register updated on that edge; bvalid next cycle, held until bready; at most one B outstanding.
//  Read: arready=1 for one cycle when arvalid&!rvalid; rvalid+rdata next cycle, held stable until rready.
//  Unmapped offset: write has no effect, bresp=2'b10; read rdata=0, rresp=2'b10. Mapped: resp 2'b00.
//  Read and write channels independent; both may complete in same cycle.
//  Prescaler: pcnt counts 0..PRESCALE when enable; tick when pcnt==PRESCALE, pcnt->0.
//   pcnt forced 0 while !enable and on any PRESCALE write.
//  On tick: if COUNT==COMPARE -> pending<=1, COUNT<=0, and if !auto_reload enable<=0; else COUNT<=COUNT+1.
//   COUNT wraps 0xFFFF_FFFF->0 with no flag (COMPARE greater than all reachable values never matches).
//  Collisions: SW write to COUNT wins over tick (no match evaluated that cycle);
//   SW CTRL write wins over one-shot clear of enable; match set wins over same-cycle STATUS W1C.
//  STATUS write with wdata[0]=0 leaves pending unchanged.
//  Reset mid-transaction: all handshakes dropped immediately (async), no response issued.
// CONFIGURATION
//  AXIL_TIMER_MTIME64_EN defined: free-running 64-bit cycle counter (counts every aclk from reset,
//   not gated by enable). 0x18 MTIME_LO read returns low word and snapshots high word;
//   0x1C MTIME_HI returns snapshot. Both read-only; writes ignored, bresp=2'b00.
//  Not defined: 0x18/0x1C unmapped (rdata 0, SLVERR); no 64-bit counter logic.
// TESTING
//  Reset then read 0x00..0x10 -> all rdata 0, rresp 0; irq 0.
//  PRESCALE=0, COMPARE=4, CTRL=0x7 -> pending+irq set 5 ticks after enable; COUNT back to 0; enable stays 1;
//   irq repeats every 5 clks after first match.
//  PRESCALE=3, COMPARE=1, CTRL=0x5 (one-shot) -> match after 8 clks, CTRL reads 0x4, COUNT 0, irq 1;
//   write STATUS=1 -> irq 0.
//  W1C on STATUS in same cycle as match -> pending remains 1; COUNT write on tick cycle -> written value read back.
//  Write 0x20 and read 0x20 -> bresp 2'b10, rresp 2'b10, rdata 0; hold bready/rready low 5 clks -> bvalid/rvalid
//   and rdata stable; awvalid before wvalid by 3 clks -> accepted only when both valid.
//  With AXIL_TIMER_MTIME64_EN: after 2^32+10 clks read 0x18 then 0x1C -> HI=1, LO>=10. Without: SLVERR.

Source files
------------

// File: rtl/axil_timer.sv
// axil_timer: AXI-Lite prescaled compare timer with level irq and W1C pending flag.
// Define AXIL_TIMER_MTIME64_EN to add a free-running 64-bit cycle counter at 0x18/0x1C.
module axil_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic                  irq
);
    logic        enable, auto_reload, irq_en, pending;
    logic [31:0] count, compare, rd_val;
    logic [15:0] prescale, pcnt;
    logic [5:0]  waddr, raddr;
    logic        wr_go, rd_go, w_ok, rd_ok, tick, hit;
    logic        wr_ctrl, wr_stat, wr_count, wr_cmp, wr_pre;
    logic        unused_bits;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        for (int i = 0; i < 4; i++) merge[i*8 +: 8] = s[i] ? d[i*8 +: 8] : old[i*8 +: 8];
    endfunction

    assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[ADDR_WIDTH-1:8],
                           s_axil_awaddr[1:0], s_axil_araddr[ADDR_WIDTH-1:8], s_axil_araddr[1:0]};

    assign waddr = s_axil_awaddr[7:2];
    assign raddr = s_axil_araddr[7:2];
    // Ready is combinational so AW and W are only ever taken together
    assign wr_go = aresetn & s_axil_awvalid & s_axil_wvalid & ~s_axil_bvalid;
    assign rd_go = aresetn & s_axil_arvalid & ~s_axil_rvalid;
    assign s_axil_awready = wr_go;
    assign s_axil_wready  = wr_go;
    assign s_axil_arready = rd_go;

    assign wr_ctrl  = wr_go & (waddr == 6'd0);
    assign wr_stat  = wr_go & (waddr == 6'd1);
    assign wr_count = wr_go & (waddr == 6'd2);
    assign wr_cmp   = wr_go & (waddr == 6'd3);
    assign wr_pre   = wr_go & (waddr == 6'd4);

    assign tick = enable & (pcnt == prescale);
    assign hit  = tick & (count == compare) & ~wr_count;
    assign irq  = pending & irq_en;

`ifdef AXIL_TIMER_MTIME64_EN
    logic [63:0] mtime;
    logic [31:0] mtime_snap;
    assign w_ok = (waddr <= 6'd4) | (waddr == 6'd6) | (waddr == 6'd7);
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mtime      <= '0;
            mtime_snap <= '0;
        end else begin
            mtime <= mtime + 64'd1;
            if (rd_go && raddr == 6'd6) mtime_snap <= mtime[63:32];
        end
    end
`else
    assign w_ok = waddr <= 6'd4;
`endif

    always_comb begin
        rd_ok  = 1'b1;
        rd_val = '0;
        case (raddr)
            6'd0: rd_val = {29'd0, irq_en, auto_reload, enable};
            6'd1: rd_val = {31'd0, pending};
            6'd2: rd_val = count;
            6'd3: rd_val = compare;
            6'd4: rd_val = {16'd0, prescale};
`ifdef AXIL_TIMER_MTIME64_EN
            6'd6: rd_val = mtime[31:0];
            6'd7: rd_val = mtime_snap;
`endif
            default: rd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= 2'b00;
        end else if (wr_go) begin
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= w_ok ? 2'b00 : 2'b10;
        end else if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rresp  <= 2'b00;
            s_axil_rdata  <= '0;
        end else if (rd_go) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rresp  <= rd_ok ? 2'b00 : 2'b10;
            s_axil_rdata  <= rd_val;
        end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

    // Software writes take priority over timer updates; a match beats a same-cycle W1C
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            {irq_en, auto_reload, enable} <= 3'b000;
            pending  <= 1'b0;
            count    <= '0;
            compare  <= '0;
            prescale <= '0;
            pcnt     <= '0;
        end else begin
            if (wr_ctrl && s_axil_wstrb[0]) {irq_en, auto_reload, enable} <= s_axil_wdata[2:0];
            else if (hit && !auto_reload) enable <= 1'b0;
            if (hit) pending <= 1'b1;
            else if (wr_stat && s_axil_wstrb[0] && s_axil_wdata[0]) pending <= 1'b0;
            if (wr_count) count <= merge(count, s_axil_wdata, s_axil_wstrb);
            else if (tick) count <= (count == compare) ? '0 : count + 32'd1;
            if (wr_cmp) compare <= merge(compare, s_axil_wdata, s_axil_wstrb);
            if (wr_pre && s_axil_wstrb[0]) prescale[7:0] <= s_axil_wdata[7:0];
            if (wr_pre && s_axil_wstrb[1]) prescale[15:8] <= s_axil_wdata[15:8];
            pcnt <= (!enable || wr_pre || tick) ? '0 : pcnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_axil_timer.sv
// tb_axil_timer: register table, timing corner cases and randomized timer checks for axil_timer.
module tb_axil_timer;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, irq;
    logic [1:0]  bresp, rresp;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic [1:0]  resp;
    } vec_t;

    axil_timer dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
        .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready), .irq(irq)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout want handshake", nm);
    endtask

    // acc returns the index of the clock edge on which the address was accepted
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold, output logic [1:0] resp, output int acc);
        int n = 0;
        @(negedge aclk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = (hold == 0);
        #1;
        while (!awready && n < 50) begin @(negedge aclk); #1; n++; end
        if (!awready) fail("wr_accept");
        acc = cyc + 1;
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        if (!bvalid) fail("wr_bvalid");
        resp = bresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            chk("b_hold_valid", bvalid, 1);
            chk("b_hold_resp", bresp, resp);
        end
        bready = 1;
        @(posedge aclk); #1;
        bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                            output logic [1:0] resp, output int acc);
        int n = 0;
        @(negedge aclk);
        araddr = a; arvalid = 1; rready = (hold == 0);
        #1;
        while (!arready && n < 50) begin @(negedge aclk); #1; n++; end
        if (!arready) fail("rd_accept");
        acc = cyc + 1;
        @(posedge aclk); #1;
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge aclk); n++; end
        if (!rvalid) fail("rd_rvalid");
        d = rdata;
        resp = rresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk);
            chk("r_hold_valid", rvalid, 1);
            chk("r_hold_data", rdata, d);
            chk("r_hold_resp", rresp, resp);
        end
        rready = 1;
        @(posedge aclk); #1;
        rready = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, output int acc);
        logic [1:0] r;
        axi_write(a, d, 4'hF, 0, r, acc);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        int          acc;
        axi_read(a, 0, d, r, acc);
        chk(nm, d, exp);
    endtask

    task automatic wait_irq(input int limit, output int at);
        int n = 0;
        while (!irq && n < limit) begin @(negedge aclk); n++; end
        if (!irq) fail("irq_wait");
        at = cyc;
    endtask

    task automatic wait_until(input int c);
        do @(negedge aclk); while (cyc < c);
    endtask

    // Timer state seen j edges after the enabling write: {enable, pending, count}
    function automatic logic [33:0] model(input int p, input int c, input int au, input int j);
        int t = (j - 1) / (p + 1);
        if (au != 0) return {1'b1, t > c, 32'(t % (c + 1))};
        return (t <= c) ? {1'b1, 1'b0, 32'(t)} : {1'b0, 1'b1, 32'd0};
    endfunction

    initial begin
        vec_t        v[$];
        logic [31:0] d;
        logic [1:0]  r;
        logic [33:0] m;
        int          acc, acc2, at, p, c, au, ie;

        awaddr = 0; wdata = 0; wstrb = 0; awvalid = 0; wvalid = 0; bready = 0;
        araddr = 0; arvalid = 0; rready = 0; awprot = 0; arprot = 0;
        repeat (3) @(negedge aclk);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_irq", irq, 0);
        aresetn = 1;

        v.push_back('{0, 32'h00, 0, 0, 32'h0, 2'b00});
        v.push_back('{0, 32'h04, 0, 0, 32'h0, 2'b00});
        v.push_back('{0, 32'h08, 0, 0, 32'h0, 2'b00});
        v.push_back('{0, 32'h0C, 0, 0, 32'h0, 2'b00});
        v.push_back('{0, 32'h10, 0, 0, 32'h0, 2'b00});
        v.push_back('{1, 32'h0C, 32'hDEADBEEF, 4'hF, 0, 2'b00});
        v.push_back('{0, 32'h0C, 0, 0, 32'hDEADBEEF, 2'b00});
        v.push_back('{1, 32'h0C, 32'h11223344, 4'h5, 0, 2'b00});
        v.push_back('{0, 32'h10C, 0, 0, 32'hDE22BE44, 2'b00});
        v.push_back('{1, 32'h10, 32'hABCD1234, 4'hF, 0, 2'b00});
        v.push_back('{0, 32'h10, 0, 0, 32'h00001234, 2'b00});
        v.push_back('{1, 32'h00, 32'hFFFFFFF2, 4'hF, 0, 2'b00});
        v.push_back('{0, 32'h00, 0, 0, 32'h2, 2'b00});
        v.push_back('{1, 32'h08, 32'hAAAAAA55, 4'h1, 0, 2'b00});
        v.push_back('{0, 32'h08, 0, 0, 32'h55, 2'b00});
        v.push_back('{1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 2'b10});
        v.push_back('{0, 32'h20, 0, 0, 32'h0, 2'b10});
        v.push_back('{0, 32'h14, 0, 0, 32'h0, 2'b10});
`ifndef AXIL_TIMER_MTIME64_EN
        v.push_back('{0, 32'h18, 0, 0, 32'h0, 2'b10});
        v.push_back('{0, 32'h1C, 0, 0, 32'h0, 2'b10});
`endif
        foreach (v[i]) begin
            if (v[i].wr) begin
                axi_write(v[i].addr, v[i].data, v[i].strb, 0, r, acc);
                chk($sformatf("vec%0d_bresp", i), r, v[i].resp);
            end else begin
                axi_read(v[i].addr, 0, d, r, acc);
                chk($sformatf("vec%0d_rdata", i), d, v[i].exp);
                chk($sformatf("vec%0d_rresp", i), r, v[i].resp);
            end
        end

        // auto-reload: first match 5 edges after enable, then every 5
        wr(32'h00, 0, acc); wr(32'h04, 1, acc); wr(32'h08, 0, acc);
        wr(32'h10, 0, acc); wr(32'h0C, 4, acc); wr(32'h00, 7, acc);
        wait_irq(100, at);
        chk("auto_first_irq", at - acc, 5);
        wr(32'h04, 1, acc2);
        chk("auto_w1c_clears", irq, 0);
        wait_irq(100, at);
        chk("auto_second_irq", at - acc, 10);
        rd_chk("auto_ctrl", 32'h00, 7);

        // one-shot with prescale 3
        wr(32'h00, 0, acc); wr(32'h04, 1, acc); wr(32'h08, 0, acc);
        wr(32'h10, 3, acc); wr(32'h0C, 1, acc); wr(32'h00, 5, acc);
        wait_irq(100, at);
        chk("oneshot_irq", at - acc, 8);
        rd_chk("oneshot_ctrl", 32'h00, 4);
        rd_chk("oneshot_count", 32'h08, 0);
        chk("oneshot_irq_held", irq, 1);
        wr(32'h04, 0, acc2);
        chk("status_w0_keeps", irq, 1);
        wr(32'h04, 1, acc2);
        chk("oneshot_cleared", irq, 0);

        // W1C landing on the match edge
        wr(32'h00, 0, acc); wr(32'h04, 1, acc); wr(32'h08, 0, acc);
        wr(32'h10, 0, acc); wr(32'h0C, 9, acc); wr(32'h00, 1, acc);
        wait_until(acc + 8);
        axi_write(32'h04, 1, 4'hF, 0, r, acc2);
        chk("w1c_collide_edge", acc2 - acc, 10);
        rd_chk("w1c_collide_pending", 32'h04, 1);

        // COUNT write landing on a tick that would otherwise match
        wr(32'h00, 0, acc); wr(32'h04, 1, acc); wr(32'h08, 0, acc);
        wr(32'h10, 50, acc); wr(32'h0C, 0, acc); wr(32'h00, 3, acc);
        wait_until(acc + 49);
        axi_write(32'h08, 32'h77, 4'hF, 0, r, acc2);
        chk("cntwr_collide_edge", acc2 - acc, 51);
        rd_chk("cntwr_value", 32'h08, 32'h77);
        rd_chk("cntwr_no_match", 32'h04, 0);
        wr(32'h00, 0, acc);

        // backpressure and split AW/W
        axi_write(32'h20, 32'h1, 4'hF, 5, r, acc);
        chk("bp_bresp", r, 2'b10);
        axi_read(32'h20, 5, d, r, acc);
        chk("bp_rresp", r, 2'b10);
        chk("bp_rdata", d, 0);
        wr(32'h0C, 32'hCAFEF00D, acc);
        axi_read(32'h0C, 5, d, r, acc);
        chk("bp_rdata_mapped", d, 32'hCAFEF00D);
        @(negedge aclk);
        awaddr = 32'h0C; wdata = 32'h5A5A0001; wstrb = 4'hF; awvalid = 1; wvalid = 0; bready = 1;
        for (int i = 0; i < 3; i++) begin #1; chk("aw_only_ready", awready, 0); @(negedge aclk); end
        wvalid = 1;
        #1;
        chk("aw_w_ready", awready & wready, 1);
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge aclk);
        chk("aw_w_bvalid", bvalid, 1);
        @(posedge aclk); #1;
        bready = 0;
        rd_chk("aw_w_value", 32'h0C, 32'h5A5A0001);

        // randomized timer configurations against the arithmetic model
        for (int k = 0; k < 12; k++) begin
            p = $urandom_range(0, 3); c = $urandom_range(0, 6);
            au = $urandom_range(0, 1); ie = $urandom_range(0, 1);
            wr(32'h00, 0, acc); wr(32'h04, 1, acc); wr(32'h08, 0, acc);
            wr(32'h10, p, acc); wr(32'h0C, c, acc);
            wr(32'h00, {29'd0, ie[0], au[0], 1'b1}, acc);
            repeat ($urandom_range(0, 40)) @(negedge aclk);
            axi_read(32'h08, 0, d, r, acc2);
            m = model(p, c, au, acc2 - acc);
            chk($sformatf("rnd%0d_count", k), d, m[31:0]);
            axi_read(32'h04, 0, d, r, acc2);
            m = model(p, c, au, acc2 - acc);
            chk($sformatf("rnd%0d_pending", k), d, {31'd0, m[32]});
            axi_read(32'h00, 0, d, r, acc2);
            m = model(p, c, au, acc2 - acc);
            chk($sformatf("rnd%0d_ctrl", k), d, {29'd0, ie[0], au[0], m[33]});
        end
        wr(32'h00, 0, acc);

        // async reset with a read response pending
        @(negedge aclk);
        araddr = 32'h0C; arvalid = 1; rready = 0;
        @(posedge aclk); #1;
        arvalid = 0;
        chk("midrst_rvalid_pre", rvalid, 1);
        aresetn = 0;
        #1;
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_rdata", rdata, 0);
        @(negedge aclk);
        aresetn = 1;
        rd_chk("midrst_compare", 32'h0C, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
